// File: rtl/axicb_pkg.sv
// Shared crossbar definitions: master index width helper and the AW lock state.
package axicb_pkg;

  typedef enum logic {UNLOCKED, LOCKED} aw_lock_e;

  function automatic int mst_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axicb_slv_wr_arbiter_if.sv
// AW/W bundle between the per-master stage and one slave write path.
// slave modport = arbiter view, master modport = surrounding environment.
interface axicb_slv_wr_arbiter_if #(
  parameter int MST_NB = 4,
  parameter int AWCH_W = 8,
  parameter int WCH_W  = 8
);
  logic [MST_NB-1:0]        i_awvalid;
  logic [MST_NB-1:0]        i_awready;
  logic [MST_NB*AWCH_W-1:0] i_awch;
  logic [MST_NB-1:0]        i_wvalid;
  logic [MST_NB-1:0]        i_wready;
  logic [MST_NB-1:0]        i_wlast;
  logic [MST_NB*WCH_W-1:0]  i_wch;
  logic                     o_awvalid;
  logic                     o_awready;
  logic [AWCH_W-1:0]        o_awch;
  logic                     o_wvalid;
  logic                     o_wready;
  logic                     o_wlast;
  logic [WCH_W-1:0]         o_wch;

  modport slave (
    input  i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, o_awready, o_wready,
    output i_awready, i_wready, o_awvalid, o_awch, o_wvalid, o_wlast, o_wch
  );

  modport master (
    output i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, o_awready, o_wready,
    input  i_awready, i_wready, o_awvalid, o_awch, o_wvalid, o_wlast, o_wch
  );
endinterface

// File: rtl/axicb_rr_arbiter.sv
// Round-robin arbiter with a lock that freezes the selection until ack,
// keeping the downstream valid stable. Shared with the AR-channel arbiter.
module axicb_rr_arbiter
  import axicb_pkg::*;
#(
  parameter  int REQ_NB = 4,
  localparam int IDX_W  = mst_idx_w(REQ_NB)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [REQ_NB-1:0] req,
  input  logic              en,
  input  logic              ack,
  output logic              vld,
  output logic [REQ_NB-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx
);

  aw_lock_e         state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;

  // first requester at or after the pointer, wrapping modulo REQ_NB
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      if (!sel_found && req[(int'(ptr_q) + i) % REQ_NB]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'((int'(ptr_q) + i) % REQ_NB);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    vld        = 1'b0;
    gnt_idx    = '0;
    case (state_q)
      UNLOCKED: begin
        if (en && sel_found) begin
          vld     = 1'b1;
          gnt_idx = sel_idx;
          if (!ack) begin
            state_d    = LOCKED;
            lock_idx_d = sel_idx;
          end
        end
      end
      LOCKED: begin
        vld     = 1'b1;
        gnt_idx = lock_idx_q;
      end
      default: state_d = UNLOCKED;
    endcase
    if (vld && ack) begin
      state_d = UNLOCKED;
      ptr_d   = (gnt_idx == IDX_W'(REQ_NB - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_comb begin
    gnt = '0;
    if (vld) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= UNLOCKED;
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/axicb_slv_wr_arbiter.sv
// Slave-side AW/W arbiter: round-robin AW grants queued in a grant FIFO that
// steers W bursts in grant order. Optional W stall watchdog: AXICB_W_TIMEOUT_EN.
module axicb_slv_wr_arbiter
  import axicb_pkg::*;
#(
  parameter int MST_NB         = 4,
  parameter int GNT_FIFO_DEPTH = 4,
  parameter int AWCH_W         = 8,
  parameter int WCH_W          = 8
`ifdef AXICB_W_TIMEOUT_EN
  ,
  parameter int W_TIMEOUT      = 1023
`endif
) (
  input logic                   aclk,
  input logic                   aresetn,
  axicb_slv_wr_arbiter_if.slave bus
`ifdef AXICB_W_TIMEOUT_EN
  ,
  output logic                  o_w_timeout
`endif
);

  localparam int IDX_W = mst_idx_w(MST_NB);
  localparam int PTR_W = $clog2(GNT_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              aw_vld, aw_en, aw_hs;
  logic [MST_NB-1:0] aw_gnt;
  logic [IDX_W-1:0]  aw_idx;

  logic [IDX_W-1:0]  fifo_mem [GNT_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              fifo_full, fifo_empty, push, pop;
  logic [IDX_W-1:0]  head;
  logic              w_hs;
  logic [MST_NB-1:0] w_rdy;

  assign fifo_full  = (cnt_q == CNT_W'(GNT_FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  // reset also masks the combinational path so nothing is offered while held
  assign aw_en      = aresetn & ~fifo_full;

  axicb_rr_arbiter #(.REQ_NB(MST_NB)) u_aw_arb (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req     (bus.i_awvalid),
    .en      (aw_en),
    .ack     (bus.o_awready),
    .vld     (aw_vld),
    .gnt     (aw_gnt),
    .gnt_idx (aw_idx)
  );

  assign aw_hs         = aw_vld & bus.o_awready;
  assign bus.o_awvalid = aw_vld;
  assign bus.o_awch    = aw_vld ? bus.i_awch[aw_idx*AWCH_W +: AWCH_W] : '0;
  assign bus.i_awready = aw_gnt & {MST_NB{bus.o_awready}};

  // strict full: no push while full, even alongside a pop
  assign push = aw_hs & ~fifo_full;
  assign head = fifo_mem[rd_ptr_q];

  assign bus.o_wvalid = ~fifo_empty & bus.i_wvalid[head];
  assign bus.o_wlast  = ~fifo_empty & bus.i_wlast[head];
  assign bus.o_wch    = fifo_empty ? '0 : bus.i_wch[head*WCH_W +: WCH_W];
  assign w_hs         = bus.o_wvalid & bus.o_wready;
  assign pop          = w_hs & bus.o_wlast;

  always_comb begin
    w_rdy = '0;
    if (!fifo_empty) w_rdy[head] = bus.o_wready;
  end
  assign bus.i_wready = w_rdy;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr_q] <= aw_idx;
  end

`ifdef AXICB_W_TIMEOUT_EN
  logic [15:0] to_cnt_q;

  // flag rises on the same edge the counter reaches W_TIMEOUT
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      to_cnt_q    <= '0;
      o_w_timeout <= 1'b0;
    end else if (fifo_empty || w_hs) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != '1) begin
      to_cnt_q <= to_cnt_q + 16'd1;
      if (32'(to_cnt_q) + 32'd1 >= 32'(W_TIMEOUT)) o_w_timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axicb_slv_wr_arbiter.sv
// Directed bench for axicb_slv_wr_arbiter: RR order, lock, strict full,
// W ordering, mid-burst reset and (with AXICB_W_TIMEOUT_EN) the stall flag.
module tb_axicb_slv_wr_arbiter;
  localparam int MST_NB = 4;
  localparam int AWCH_W = 8;
  localparam int WCH_W  = 8;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  int   nvec    = 0;
  int   nerr    = 0;

  axicb_slv_wr_arbiter_if #(.MST_NB(MST_NB), .AWCH_W(AWCH_W), .WCH_W(WCH_W)) bus ();

`ifdef AXICB_W_TIMEOUT_EN
  logic o_w_timeout;
`endif

  axicb_slv_wr_arbiter #(
    .MST_NB(MST_NB), .GNT_FIFO_DEPTH(4), .AWCH_W(AWCH_W), .WCH_W(WCH_W)
`ifdef AXICB_W_TIMEOUT_EN
    , .W_TIMEOUT(8)
`endif
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
`ifdef AXICB_W_TIMEOUT_EN
    , .o_w_timeout (o_w_timeout)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic aw_chk(input string tag, input logic vld, input logic [7:0] ch,
                        input logic [3:0] rdy);
    #1;
    chk({tag, "_awvalid"}, 32'(bus.o_awvalid), 32'(vld));
    chk({tag, "_awch"},    32'(bus.o_awch),    32'(ch));
    chk({tag, "_awready"}, 32'(bus.i_awready), 32'(rdy));
  endtask

  task automatic w_chk(input string tag, input logic vld, input logic [7:0] ch,
                       input logic last, input logic [3:0] rdy);
    #1;
    chk({tag, "_wvalid"}, 32'(bus.o_wvalid), 32'(vld));
    chk({tag, "_wch"},    32'(bus.o_wch),    32'(ch));
    chk({tag, "_wlast"},  32'(bus.o_wlast),  32'(last));
    chk({tag, "_wready"}, 32'(bus.i_wready), 32'(rdy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    int hs[4];
    hs = '{0, 2, 3, 1};
    bus.i_awch   = 32'hA3A2A1A0;
    bus.i_wch    = 32'hD3D2D1D0;
    // reset held with traffic present: everything must stay quiet
    bus.i_awvalid = 4'b0001;
    bus.i_wvalid  = 4'b1111;
    bus.i_wlast   = 4'b1111;
    bus.o_awready = 1'b1;
    bus.o_wready  = 1'b1;
    #1;
    aw_chk("rst", 1'b0, 8'h00, 4'b0000);
    w_chk("rst", 1'b0, 8'h00, 1'b0, 4'b0000);
    repeat (2) @(posedge aclk);
    #1;
    bus.i_awvalid = '0;
    bus.i_wvalid  = '0;
    bus.i_wlast   = '0;
    bus.o_wready  = 1'b0;
    aresetn       = 1'b1;

    // masters 0 and 2 together: 0 then 2, pointer lands on 3
    bus.i_awvalid = 4'b0101; aw_chk("t1_g0", 1'b1, 8'hA0, 4'b0001); tick();
    bus.i_awvalid = 4'b0100; aw_chk("t1_g2", 1'b1, 8'hA2, 4'b0100); tick();
    bus.i_awvalid = 4'b1111; aw_chk("t1_ptr3", 1'b1, 8'hA3, 4'b1000); tick();
    bus.i_awvalid = 4'b0000; aw_chk("t1_idle", 1'b0, 8'h00, 4'b0000);
    // grant FIFO holds [0,2,3]
    bus.o_wready = 1'b1; bus.i_wvalid = 4'b0101; bus.i_wlast = 4'b0101;
    w_chk("t1_w0", 1'b1, 8'hD0, 1'b1, 4'b0001); tick();
    w_chk("t1_w2", 1'b1, 8'hD2, 1'b1, 4'b0100); tick();
    w_chk("t1_w3wait", 1'b0, 8'hD3, 1'b0, 4'b1000);
    bus.i_wvalid = 4'b1000; bus.i_wlast = 4'b1000;
    w_chk("t1_w3", 1'b1, 8'hD3, 1'b1, 4'b1000); tick();
    bus.i_wvalid = 4'b1111; bus.i_wlast = 4'b1111;
    w_chk("t1_empty", 1'b0, 8'h00, 1'b0, 4'b0000);
    bus.i_wvalid = '0; bus.i_wlast = '0; bus.o_wready = 1'b0;

    // pointer 0: master 1 locked while master 0 joins
    bus.o_awready = 1'b0;
    bus.i_awvalid = 4'b0010; aw_chk("t2_sel1", 1'b1, 8'hA1, 4'b0000); tick();
    bus.i_awvalid = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      aw_chk("t2_lock", 1'b1, 8'hA1, 4'b0000); tick();
    end
    bus.o_awready = 1'b1; aw_chk("t2_hs", 1'b1, 8'hA1, 4'b0010); tick();
    bus.i_awvalid = 4'b0001; aw_chk("t2_g0", 1'b1, 8'hA0, 4'b0001); tick();
    // fill: FIFO becomes [1,0,2,3]
    bus.i_awvalid = 4'b1100; aw_chk("t3_g2", 1'b1, 8'hA2, 4'b0100); tick();
    bus.i_awvalid = 4'b1000; aw_chk("t3_g3", 1'b1, 8'hA3, 4'b1000); tick();
    bus.i_awvalid = 4'b0010; aw_chk("t3_full", 1'b0, 8'h00, 4'b0000); tick();
    aw_chk("t3_full2", 1'b0, 8'h00, 4'b0000);
    bus.o_wready = 1'b1; bus.i_wvalid = 4'b0010; bus.i_wlast = 4'b0010;
    w_chk("t3_pop", 1'b1, 8'hD1, 1'b1, 4'b0010);
    aw_chk("t3_strict", 1'b0, 8'h00, 4'b0000); tick();
    bus.i_wvalid = '0; bus.i_wlast = '0;
    aw_chk("t3_regrant", 1'b1, 8'hA1, 4'b0010); tick();
    bus.i_awvalid = '0;
    // drain [0,2,3,1]
    for (int i = 0; i < 4; i++) begin
      bus.i_wvalid = 4'(1 << hs[i]); bus.i_wlast = 4'(1 << hs[i]);
      w_chk("drain", 1'b1, 8'(8'hD0 + hs[i]), 1'b1, 4'(1 << hs[i])); tick();
    end
    bus.i_wvalid = '0; bus.i_wlast = '0;

    // grants [1,3]; master 3 waits behind master 1's 3-beat burst
    bus.i_awvalid = 4'b0010; aw_chk("t4_g1", 1'b1, 8'hA1, 4'b0010); tick();
    bus.i_awvalid = 4'b1000; aw_chk("t4_g3", 1'b1, 8'hA3, 4'b1000); tick();
    bus.i_awvalid = '0;
    for (int b = 1; b <= 3; b++) begin
      bus.i_wvalid = 4'b1010;
      bus.i_wch[15:8] = 8'(8'h10 + b);
      bus.i_wlast = (b == 3) ? 4'b0010 : 4'b0000;
      w_chk("t4_m1", 1'b1, 8'(8'h10 + b), b == 3, 4'b0010); tick();
    end
    bus.i_wch[15:8] = 8'hD1;
    bus.i_wvalid = 4'b1000; bus.i_wlast = 4'b0000;
    w_chk("t4_m3b1", 1'b1, 8'hD3, 1'b0, 4'b1000); tick();

    // reset during beat 2 of master 3's 4-beat burst
    bus.i_awvalid = 4'b0001;
    aresetn = 1'b0;
    aw_chk("t5_rst", 1'b0, 8'h00, 4'b0000);
    w_chk("t5_rst", 1'b0, 8'h00, 1'b0, 4'b0000);
    tick();
    bus.i_awvalid = '0; bus.i_wvalid = '0;
    aresetn = 1'b1;
    bus.i_awvalid = 4'b1100; aw_chk("t5_g2", 1'b1, 8'hA2, 4'b0100); tick();
    bus.i_awvalid = '0;
    bus.i_wvalid = 4'b1100; bus.i_wlast = 4'b1100;
    w_chk("t5_w2", 1'b1, 8'hD2, 1'b1, 4'b0100); tick();
    bus.i_wvalid = '0; bus.i_wlast = '0;
    w_chk("t5_empty", 1'b0, 8'h00, 1'b0, 4'b0000);

`ifdef AXICB_W_TIMEOUT_EN
    chk("to_clear", 32'(o_w_timeout), 32'd0);
    bus.i_awvalid = 4'b0001; aw_chk("to_g0", 1'b1, 8'hA0, 4'b0001); tick();
    bus.i_awvalid = '0;
    repeat (7) tick();
    chk("to_early", 32'(o_w_timeout), 32'd0);
    tick();
    chk("to_set", 32'(o_w_timeout), 32'd1);
    bus.i_wvalid = 4'b0001; bus.i_wlast = 4'b0001; tick();
    bus.i_wvalid = '0; bus.i_wlast = '0;
    tick();
    chk("to_sticky", 32'(o_w_timeout), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
